// File: rtl/counter_modn_pkg.sv
// Shared state encoding and terminal-detect helper for the modulo-N counter.
// Optional compare path is enabled by defining COUNTER_MODN_CMP_EN.
package counter_modn_pkg;

    typedef logic state_t;

    localparam state_t S_RUN  = 1'b0;
    localparam state_t S_HALT = 1'b1;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Up counting is terminal at or above top; down counting at zero or when
    // top has been lowered beneath the current count.
    function automatic logic term_hit(
        input logic up,
        input logic ge_top,
        input logic gt_top,
        input logic at_zero
    );
        return (up == DIR_UP) ? ge_top : (at_zero | gt_top);
    endfunction

endpackage

// File: rtl/counter_modn_next.sv
// Combinational next-count, terminal flag, load clamp and restart value.
module counter_modn_next #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_count,
    input  logic [WIDTH-1:0] i_top,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_up,
    input  logic             i_oneshot,
    output logic [WIDTH-1:0] o_step_c,
    output logic [WIDTH-1:0] o_load_c,
    output logic [WIDTH-1:0] o_start_c,
    output logic             o_term_c
);
    import counter_modn_pkg::*;

    logic ge_top;
    logic gt_top;
    logic at_zero;

    assign ge_top  = (i_count >= i_top);
    assign gt_top  = (i_count >  i_top);
    assign at_zero = (i_count == WIDTH'(0));

    assign o_term_c = term_hit(i_up, ge_top, gt_top, at_zero);

    // Terminal steps wrap in free-run mode and stick at the end value in one-shot.
    always_comb begin
        o_step_c = i_count;
        if (o_term_c) begin
            if (i_oneshot) begin
                o_step_c = (i_up == DIR_UP) ? i_top : WIDTH'(0);
            end else begin
                o_step_c = (i_up == DIR_UP) ? WIDTH'(0) : i_top;
            end
        end else if (i_up == DIR_UP) begin
            o_step_c = i_count + WIDTH'(1);
        end else begin
            o_step_c = i_count - WIDTH'(1);
        end
    end

    assign o_load_c  = (i_data > i_top) ? i_top : i_data;
    assign o_start_c = (i_up == DIR_UP) ? WIDTH'(0) : i_top;

endmodule

// File: rtl/counter_modn.sv
// Modulo-N up/down counter with terminal-count pulse and one-shot run/halt FSM.
// Define COUNTER_MODN_CMP_EN to build the registered compare output.
module counter_modn #(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_up,
    input  logic             i_ld,
    input  logic [WIDTH-1:0] i_data,
    input  logic [WIDTH-1:0] i_top,
    input  logic             i_oneshot,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_cmp,
    output logic [WIDTH-1:0] o_data,
    output logic             o_tc,
    output logic             o_busy,
    output logic             o_cmp
);
    import counter_modn_pkg::*;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             tc_q;
    logic             tc_d;

    logic [WIDTH-1:0] step_c;
    logic [WIDTH-1:0] load_c;
    logic [WIDTH-1:0] start_c;
    logic             term_c;

    counter_modn_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .i_count   (data_q),
        .i_top     (i_top),
        .i_data    (i_data),
        .i_up      (i_up),
        .i_oneshot (i_oneshot),
        .o_step_c  (step_c),
        .o_load_c  (load_c),
        .o_start_c (start_c),
        .o_term_c  (term_c)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_RUN;
            data_q  <= RST_VAL;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            tc_q    <= tc_d;
        end
    end

    // Load beats restart, restart only applies in HALT, counting only in RUN.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        tc_d    = 1'b0;
        if (i_ld) begin
            data_d  = load_c;
            state_d = S_RUN;
        end else if (state_q == S_HALT) begin
            if (i_start) begin
                data_d  = start_c;
                state_d = S_RUN;
            end
        end else if (i_en) begin
            data_d = step_c;
            tc_d   = term_c;
            if (term_c && i_oneshot) begin
                state_d = S_HALT;
            end
        end
    end

    assign o_data = data_q;
    assign o_tc   = tc_q;
    assign o_busy = (state_q == S_RUN);

`ifdef COUNTER_MODN_CMP_EN
    logic cmp_q;
    logic cmp_d;

    // Compare against the next count so o_cmp lines up with o_data.
    assign cmp_d = (data_d < i_cmp);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cmp_q <= 1'b0;
        end else begin
            cmp_q <= cmp_d;
        end
    end

    assign o_cmp = cmp_q;
`else
    logic unused_cmp;
    assign unused_cmp = ^i_cmp;
    assign o_cmp      = 1'b0;
`endif

endmodule

// File: tb/tb_counter_modn.sv
// Scoreboard bench for counter_modn: expectations queued at drive time, checked after the edge.
module tb_counter_modn;

`ifdef COUNTER_MODN_CMP_EN
    localparam bit CMP_ON = 1'b1;
`else
    localparam bit CMP_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       up;
    logic       ld;
    logic [7:0] data;
    logic [7:0] top;
    logic       oneshot;
    logic       start;
    logic [7:0] cmp;
    logic [7:0] o_data;
    logic       o_tc;
    logic       o_busy;
    logic       o_cmp;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       rst;
        logic       ld;
        logic       start;
        logic       en;
        logic       up;
        logic       os;
        logic [7:0] data;
        logic [7:0] top;
        logic [7:0] ed;
        logic       etc;
        logic       ebusy;
    } vec_t;

    typedef struct packed {
        logic [7:0] data;
        logic       tc;
        logic       busy;
        logic       cmp;
    } exp_t;

    exp_t sb[$];

    counter_modn #(
        .WIDTH   (8),
        .RST_VAL (8'd0)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_en      (en),
        .i_up      (up),
        .i_ld      (ld),
        .i_data    (data),
        .i_top     (top),
        .i_oneshot (oneshot),
        .i_start   (start),
        .i_cmp     (cmp),
        .o_data    (o_data),
        .o_tc      (o_tc),
        .o_busy    (o_busy),
        .o_cmp     (o_cmp)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(input logic r, input logic l, input logic s, input logic e,
                               input logic u, input logic o, input logic [7:0] d,
                               input logic [7:0] t, input logic [7:0] ed,
                               input logic etc, input logic eb);
        vec_t x;
        x.rst = r; x.ld = l; x.start = s; x.en = e; x.up = u; x.os = o;
        x.data = d; x.top = t; x.ed = ed; x.etc = etc; x.ebusy = eb;
        return x;
    endfunction

    // Drive one cycle of stimulus and queue what the counter must show after the edge.
    task automatic apply(input vec_t x);
        exp_t e;
        rst = x.rst; ld = x.ld; start = x.start; en = x.en; up = x.up;
        oneshot = x.os; data = x.data; top = x.top;
        e.data = x.ed;
        e.tc   = x.etc;
        e.busy = x.ebusy;
        e.cmp  = CMP_ON && !x.rst && (x.ed < cmp);
        sb.push_back(e);
    endtask

    task automatic test_reset();
        vec_t tv[$];
        exp_t e;
        tv.push_back(v(1,1,1,1,1,0, 8'd55, 8'd9, 8'd0, 0, 1));
        tv.push_back(v(1,0,0,1,1,0, 8'd0,  8'd9, 8'd0, 0, 1));
        foreach (tv[i]) begin
            apply(tv[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({o_data, o_tc, o_busy, o_cmp} !== e) begin
                errors++;
                $display("FAIL reset[%0d] got d=%0d tc=%b busy=%b cmp=%b exp d=%0d tc=%b busy=%b cmp=%b",
                         i, o_data, o_tc, o_busy, o_cmp, e.data, e.tc, e.busy, e.cmp);
            end
        end
    endtask

    task automatic test_wrap_up();
        vec_t tv[$];
        exp_t e;
        for (int k = 1; k <= 10; k++)
            tv.push_back(v(0,0,0,1,1,0, 8'd0, 8'd9, 8'(k % 10), k == 10, 1));
        foreach (tv[i]) begin
            apply(tv[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({o_data, o_tc, o_busy, o_cmp} !== e) begin
                errors++;
                $display("FAIL wrap_up[%0d] got d=%0d tc=%b busy=%b cmp=%b exp d=%0d tc=%b busy=%b cmp=%b",
                         i, o_data, o_tc, o_busy, o_cmp, e.data, e.tc, e.busy, e.cmp);
            end
        end
    endtask

    task automatic test_wrap_down();
        vec_t tv[$];
        exp_t e;
        tv.push_back(v(0,1,0,0,1,0, 8'hFE, 8'd20, 8'd20, 0, 1));
        for (int k = 1; k <= 21; k++)
            tv.push_back(v(0,0,0,1,0,0, 8'd0, 8'd20, (k == 21) ? 8'd20 : 8'(20 - k), k == 21, 1));
        foreach (tv[i]) begin
            apply(tv[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({o_data, o_tc, o_busy, o_cmp} !== e) begin
                errors++;
                $display("FAIL wrap_down[%0d] got d=%0d tc=%b busy=%b cmp=%b exp d=%0d tc=%b busy=%b cmp=%b",
                         i, o_data, o_tc, o_busy, o_cmp, e.data, e.tc, e.busy, e.cmp);
            end
        end
    endtask

    task automatic test_priority();
        vec_t tv[$];
        exp_t e;
        tv.push_back(v(0,1,0,0,1,0, 8'd7,  8'd20, 8'd7, 0, 1));
        tv.push_back(v(0,0,0,0,1,0, 8'd0,  8'd20, 8'd7, 0, 1));
        tv.push_back(v(0,0,0,0,0,0, 8'd0,  8'd20, 8'd7, 0, 1));
        tv.push_back(v(0,0,1,0,1,0, 8'd0,  8'd20, 8'd7, 0, 1));
        tv.push_back(v(0,0,1,1,1,0, 8'd0,  8'd20, 8'd8, 0, 1));
        tv.push_back(v(1,1,1,1,1,0, 8'd99, 8'd20, 8'd0, 0, 1));
        foreach (tv[i]) begin
            apply(tv[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({o_data, o_tc, o_busy, o_cmp} !== e) begin
                errors++;
                $display("FAIL priority[%0d] got d=%0d tc=%b busy=%b cmp=%b exp d=%0d tc=%b busy=%b cmp=%b",
                         i, o_data, o_tc, o_busy, o_cmp, e.data, e.tc, e.busy, e.cmp);
            end
        end
    endtask

    task automatic test_oneshot();
        vec_t tv[$];
        exp_t e;
        tv.push_back(v(0,0,0,1,1,1, 8'd0, 8'd3, 8'd1, 0, 1));
        tv.push_back(v(0,0,0,1,1,1, 8'd0, 8'd3, 8'd2, 0, 1));
        tv.push_back(v(0,0,0,1,1,1, 8'd0, 8'd3, 8'd3, 0, 1));
        tv.push_back(v(0,0,0,1,1,1, 8'd0, 8'd3, 8'd3, 1, 0));
        for (int k = 0; k < 5; k++)
            tv.push_back(v(0,0,0,1,1,1, 8'd0, 8'd3, 8'd3, 0, 0));
        tv.push_back(v(0,0,0,1,1,0, 8'd0, 8'd3, 8'd3, 0, 0));
        tv.push_back(v(0,0,0,1,1,0, 8'd0, 8'd3, 8'd3, 0, 0));
        tv.push_back(v(0,0,1,0,1,1, 8'd0, 8'd3, 8'd0, 0, 1));
        tv.push_back(v(0,0,0,1,1,1, 8'd0, 8'd3, 8'd1, 0, 1));
        tv.push_back(v(0,0,0,1,1,1, 8'd0, 8'd3, 8'd2, 0, 1));
        tv.push_back(v(0,0,0,1,1,1, 8'd0, 8'd3, 8'd3, 0, 1));
        tv.push_back(v(0,0,0,1,1,1, 8'd0, 8'd3, 8'd3, 1, 0));
        tv.push_back(v(0,1,0,0,1,1, 8'd1, 8'd3, 8'd1, 0, 1));
        tv.push_back(v(0,0,0,1,1,1, 8'd0, 8'd3, 8'd2, 0, 1));
        tv.push_back(v(0,0,0,1,1,1, 8'd0, 8'd3, 8'd3, 0, 1));
        tv.push_back(v(0,0,0,1,1,1, 8'd0, 8'd3, 8'd3, 1, 0));
        tv.push_back(v(1,0,1,1,1,1, 8'd0, 8'd3, 8'd0, 0, 1));
        foreach (tv[i]) begin
            apply(tv[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({o_data, o_tc, o_busy, o_cmp} !== e) begin
                errors++;
                $display("FAIL oneshot[%0d] got d=%0d tc=%b busy=%b cmp=%b exp d=%0d tc=%b busy=%b cmp=%b",
                         i, o_data, o_tc, o_busy, o_cmp, e.data, e.tc, e.busy, e.cmp);
            end
        end
    endtask

    task automatic test_oneshot_down();
        vec_t tv[$];
        exp_t e;
        tv.push_back(v(0,1,0,0,0,1, 8'd2, 8'd2, 8'd2, 0, 1));
        tv.push_back(v(0,0,0,1,0,1, 8'd0, 8'd2, 8'd1, 0, 1));
        tv.push_back(v(0,0,0,1,0,1, 8'd0, 8'd2, 8'd0, 0, 1));
        tv.push_back(v(0,0,0,1,0,1, 8'd0, 8'd2, 8'd0, 1, 0));
        tv.push_back(v(0,0,0,1,0,1, 8'd0, 8'd2, 8'd0, 0, 0));
        tv.push_back(v(0,0,1,0,0,0, 8'd0, 8'd2, 8'd2, 0, 1));
        foreach (tv[i]) begin
            apply(tv[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({o_data, o_tc, o_busy, o_cmp} !== e) begin
                errors++;
                $display("FAIL oneshot_down[%0d] got d=%0d tc=%b busy=%b cmp=%b exp d=%0d tc=%b busy=%b cmp=%b",
                         i, o_data, o_tc, o_busy, o_cmp, e.data, e.tc, e.busy, e.cmp);
            end
        end
    endtask

    task automatic test_top_edges();
        vec_t tv[$];
        exp_t e;
        // top lowered beneath the count
        tv.push_back(v(0,1,0,0,1,0, 8'd50, 8'd100, 8'd50, 0, 1));
        tv.push_back(v(0,0,0,1,1,0, 8'd0,  8'd10,  8'd0,  1, 1));
        tv.push_back(v(0,1,0,0,1,0, 8'd50, 8'd100, 8'd50, 0, 1));
        tv.push_back(v(0,0,0,1,0,0, 8'd0,  8'd10,  8'd10, 1, 1));
        tv.push_back(v(0,0,0,1,0,0, 8'd0,  8'd10,  8'd9,  0, 1));
        // top of zero: every enabled step terminal, back to back
        tv.push_back(v(0,1,0,1,1,0, 8'd5,  8'd0,   8'd0,  0, 1));
        tv.push_back(v(0,0,0,1,1,0, 8'd0,  8'd0,   8'd0,  1, 1));
        tv.push_back(v(0,0,0,1,1,0, 8'd0,  8'd0,   8'd0,  1, 1));
        tv.push_back(v(0,0,0,1,1,0, 8'd0,  8'd0,   8'd0,  1, 1));
        tv.push_back(v(0,0,0,1,0,0, 8'd0,  8'd0,   8'd0,  1, 1));
        tv.push_back(v(0,0,0,1,0,0, 8'd0,  8'd0,   8'd0,  1, 1));
        tv.push_back(v(0,0,0,0,0,0, 8'd0,  8'd0,   8'd0,  0, 1));
        foreach (tv[i]) begin
            apply(tv[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({o_data, o_tc, o_busy, o_cmp} !== e) begin
                errors++;
                $display("FAIL top_edges[%0d] got d=%0d tc=%b busy=%b cmp=%b exp d=%0d tc=%b busy=%b cmp=%b",
                         i, o_data, o_tc, o_busy, o_cmp, e.data, e.tc, e.busy, e.cmp);
            end
        end
    endtask

    task automatic test_cmp_duty();
        vec_t tv[$];
        exp_t e;
        int   high_cnt;
        high_cnt = 0;
        tv.push_back(v(1,0,0,0,1,0, 8'd0, 8'd9, 8'd0, 0, 1));
        for (int k = 1; k <= 30; k++)
            tv.push_back(v(0,0,0,1,1,0, 8'd0, 8'd9, 8'(k % 10), (k % 10) == 0, 1));
        foreach (tv[i]) begin
            apply(tv[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            if (i > 0 && o_cmp === 1'b1) high_cnt++;
            checks++;
            if ({o_data, o_tc, o_busy, o_cmp} !== e) begin
                errors++;
                $display("FAIL cmp_duty[%0d] got d=%0d tc=%b busy=%b cmp=%b exp d=%0d tc=%b busy=%b cmp=%b",
                         i, o_data, o_tc, o_busy, o_cmp, e.data, e.tc, e.busy, e.cmp);
            end
        end
        checks++;
        if (high_cnt !== (CMP_ON ? 9 : 0)) begin
            errors++;
            $display("FAIL cmp_high_cycles got %0d exp %0d", high_cnt, CMP_ON ? 9 : 0);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b1; ld = 1'b0; data = 8'd0; top = 8'd9;
        oneshot = 1'b0; start = 1'b0; cmp = 8'd3;
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_priority();
        test_oneshot();
        test_oneshot_down();
        test_top_edges();
        test_cmp_duty();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
